// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state codes,
// forwarding select codes, the load MemRW code and the rd/rs match helper.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_MEM    = 2'b01;
    localparam logic [1:0] FWD_WB     = 2'b10;
    localparam logic [1:0] MEMRW_LOAD = 2'b10;

    // Wide enough for any MEM_TIMEOUT up to 1023.
    localparam int TMR_W = 10;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic wr,
                                       input logic [4:0] rs, input logic use_rs);
        return (rd != 5'd0) && wr && (rd == rs) && use_rs;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational rd/rs comparator: forwarding selects and the RAW stall request.
// Macro HAZARD_FWD_EN enables forwarding (load-use stall only); otherwise no forwarding.
module hazard_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_use_rs1,
    input  logic       i_use_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_regwrite,
    input  logic       i_ex_memread,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_regwrite,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_regwrite,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b,
    output logic       o_raw_stall
);

    logic w_ex_a, w_ex_b, w_mem_a, w_mem_b;

    assign w_ex_a  = reg_match(i_ex_rd,  i_ex_regwrite,  i_rs1, i_use_rs1);
    assign w_ex_b  = reg_match(i_ex_rd,  i_ex_regwrite,  i_rs2, i_use_rs2);
    assign w_mem_a = reg_match(i_mem_rd, i_mem_regwrite, i_rs1, i_use_rs1);
    assign w_mem_b = reg_match(i_mem_rd, i_mem_regwrite, i_rs2, i_use_rs2);

`ifdef HAZARD_FWD_EN
    // Selects are sampled into ID/EX, so an EX match lands in EX/MEM next cycle.
    assign o_fwd_a     = w_ex_a ? FWD_MEM : (w_mem_a ? FWD_WB : FWD_RF);
    assign o_fwd_b     = w_ex_b ? FWD_MEM : (w_mem_b ? FWD_WB : FWD_RF);
    assign o_raw_stall = i_ex_memread && (w_ex_a || w_ex_b);

    logic [5:0] w_unused_wb;
    assign w_unused_wb = {i_wb_rd, i_wb_regwrite};
`else
    logic w_wb_a, w_wb_b;
    logic w_unused_memread;

    // No regfile write-through, so a pending WB write also blocks decode.
    assign w_wb_a           = reg_match(i_wb_rd, i_wb_regwrite, i_rs1, i_use_rs1);
    assign w_wb_b           = reg_match(i_wb_rd, i_wb_regwrite, i_rs2, i_use_rs2);
    assign o_fwd_a          = FWD_RF;
    assign o_fwd_b          = FWD_RF;
    assign o_raw_stall      = w_ex_a || w_ex_b || w_mem_a || w_mem_b || w_wb_a || w_wb_b;
    assign w_unused_memread = i_ex_memread;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: RAW stalls, branch redirect, memory-wait freeze.
// Macro HAZARD_FWD_EN selects the forwarding build (see hazard_fwd_unit).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    input  logic             ex_br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_keep,
    output logic             pc_redirect,
    output logic             if_keep,
    output logic             if_nop,
    output logic             id_keep,
    output logic             id_nop,
    output logic             ex_keep,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t        r_state, w_next;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic [1:0]       w_fwd_a, w_fwd_b;
    logic             w_raw_stall, w_mem_stall, w_timeout;
    logic             w_pc_keep, w_pc_redirect, w_if_keep, w_if_nop;
    logic             w_id_keep, w_id_nop, w_ex_keep, w_mem_err;

    hazard_fwd_unit u_fwd (
        .i_rs1          (id_rs1),
        .i_rs2          (id_rs2),
        .i_use_rs1      (id_use_rs1),
        .i_use_rs2      (id_use_rs2),
        .i_ex_rd        (ex_rd),
        .i_ex_regwrite  (ex_regwrite),
        .i_ex_memread   (ex_memread),
        .i_mem_rd       (mem_rd),
        .i_mem_regwrite (mem_regwrite),
        .i_wb_rd        (wb_rd),
        .i_wb_regwrite  (wb_regwrite),
        .o_fwd_a        (w_fwd_a),
        .o_fwd_b        (w_fwd_b),
        .o_raw_stall    (w_raw_stall)
    );

    assign w_mem_stall = dmem_req && !dmem_ready;
    assign w_timeout   = w_mem_stall && (r_timer == TMR_W'(MEM_TIMEOUT - 1));
    assign w_timer_nxt = (w_mem_stall && !w_timeout) ? r_timer + 1'b1 : '0;

    always_comb begin
        w_next        = r_state;
        w_pc_keep     = 1'b0;
        w_pc_redirect = 1'b0;
        w_if_keep     = 1'b0;
        w_if_nop      = 1'b0;
        w_id_keep     = 1'b0;
        w_id_nop      = 1'b0;
        w_ex_keep     = 1'b0;
        w_mem_err     = 1'b0;
        if (w_mem_stall || r_state == ST_MEM_WAIT) begin
            // Whole core frozen, including the cycle the access completes.
            w_pc_keep = 1'b1;
            w_if_keep = 1'b1;
            w_id_keep = 1'b1;
            w_ex_keep = 1'b1;
            w_mem_err = w_timeout;
            w_next    = (w_mem_stall && !w_timeout) ? ST_MEM_WAIT : ST_RUN;
        end else if (r_state == ST_REDIRECT) begin
            // Drop the fetch launched in the redirect cycle; stalls are moot here.
            w_if_nop = 1'b1;
            w_next   = ST_RUN;
        end else if (ex_br_taken) begin
            w_pc_redirect = 1'b1;
            w_if_nop      = 1'b1;
            w_id_nop      = 1'b1;
            w_next        = ST_REDIRECT;
        end else if (w_raw_stall) begin
            w_pc_keep = 1'b1;
            w_if_keep = 1'b1;
            w_id_nop  = 1'b1;
            w_next    = ST_RUN;
        end else begin
            w_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_timer     <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_next;
            r_timer     <= w_timer_nxt;
            r_stall_cnt <= r_stall_cnt + CNT_W'(w_pc_keep);
            r_flush_cnt <= r_flush_cnt + CNT_W'(w_pc_redirect);
        end
    end

    // Reset overrides the combinational outputs so the pipeline sees bubbles at once.
    assign pc_keep     = !rst && w_pc_keep;
    assign pc_redirect = !rst && w_pc_redirect;
    assign if_keep     = !rst && w_if_keep;
    assign if_nop      =  rst || w_if_nop;
    assign id_keep     = !rst && w_id_keep;
    assign id_nop      =  rst || w_id_nop;
    assign ex_keep     = !rst && w_ex_keep;
    assign mem_err     = !rst && w_mem_err;
    assign fwd_a       = rst ? FWD_RF : w_fwd_a;
    assign fwd_b       = rst ? FWD_RF : w_fwd_b;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations follow HAZARD_FWD_EN if defined.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_memread;
    logic       mem_regwrite, wb_regwrite, ex_br_taken, dmem_req, dmem_ready;
    logic       pc_keep, pc_redirect, if_keep, if_nop, id_keep, id_nop, ex_keep, mem_err;
    logic [1:0] fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_stall = 0;
    int exp_flush = 0;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Control strobe vector: {pc_keep, pc_redirect, if_keep, if_nop, id_keep, id_nop, ex_keep, mem_err}
    localparam logic [7:0] C_IDLE  = 8'b0000_0000;
    localparam logic [7:0] C_STALL = 8'b1010_0100;
    localparam logic [7:0] C_BR    = 8'b0101_0100;
    localparam logic [7:0] C_REDIR = 8'b0001_0000;
    localparam logic [7:0] C_KEEP  = 8'b1010_1010;
    localparam logic [7:0] C_TOUT  = 8'b1010_1011;
    localparam logic [7:0] C_RST   = 8'b0001_0100;

    logic [7:0] ctl;
    assign ctl = {pc_keep, pc_redirect, if_keep, if_nop, id_keep, id_nop, ex_keep, mem_err};

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_br_taken(ex_br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_keep(pc_keep), .pc_redirect(pc_redirect), .if_keep(if_keep), .if_nop(if_nop),
        .id_keep(id_keep), .id_nop(id_nop), .ex_keep(ex_keep),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each control check is followed by a clock edge, so expected counters advance here.
    task automatic chk_ctl(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, ctl}, {24'd0, exp});
        if (exp[7]) exp_stall++;
        if (exp[6]) exp_flush++;
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] ea, input logic [1:0] eb);
        chk({tag, "_fwd"}, {28'd0, fwd_a, fwd_b}, {28'd0, ea, eb});
    endtask

    task automatic clr_in;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
        ex_br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        ex_rd = 5'd5; ex_regwrite = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #3;
        chk_ctl("reset_ctl", C_RST);
        chk_fwd("reset", 2'b00, 2'b00);
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_flush_cnt", flush_cnt, 32'd0);
        tick(); tick();
        rst = 1'b0;
        clr_in(); settle();
        chk_ctl("idle", C_IDLE);
        tick();

        // Destination x0 never creates a hazard.
        ex_rd = 5'd0; ex_regwrite = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; settle();
        chk_ctl("x0_ctl", C_IDLE);
        chk_fwd("x0", 2'b00, 2'b00);
        tick();

        // add x5 ; sub x7,x5,x5
        ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd5; settle();
        chk_ctl("ex_alu_ctl", FWD ? C_IDLE : C_STALL);
        chk_fwd("ex_alu", FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00);
        tick();
        chk("ex_alu_stall_cnt", stall_cnt, exp_stall);

        // Operand not actually read
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; settle();
        chk_ctl("no_use_ctl", C_IDLE);
        tick();

        // EX/MEM match beats MEM/WB match on rs1
        clr_in();
        ex_rd = 5'd5; ex_regwrite = 1'b1; mem_rd = 5'd5; mem_regwrite = 1'b1;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd6; id_use_rs2 = 1'b1; settle();
        chk_ctl("prio_ctl", FWD ? C_IDLE : C_STALL);
        chk_fwd("prio", FWD ? 2'b01 : 2'b00, 2'b00);
        tick();

        // MEM-stage producer on rs2 only
        clr_in();
        mem_rd = 5'd7; mem_regwrite = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1; settle();
        chk_ctl("mem_b_ctl", FWD ? C_IDLE : C_STALL);
        chk_fwd("mem_b", 2'b00, FWD ? 2'b10 : 2'b00);
        tick();

        // lw x5 ; add x6,x5,x1 -- load walks EX -> MEM -> WB while add waits in decode
        clr_in();
        ex_rd = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd1; id_use_rs2 = 1'b1; settle();
        chk_ctl("lu_ex_ctl", C_STALL);
        tick();
        ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd5; mem_regwrite = 1'b1; settle();
        chk_ctl("lu_mem_ctl", FWD ? C_IDLE : C_STALL);
        chk_fwd("lu_mem", FWD ? 2'b10 : 2'b00, 2'b00);
        tick();
        mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd5; wb_regwrite = 1'b1; settle();
        chk_ctl("lu_wb_ctl", FWD ? C_IDLE : C_STALL);
        chk_fwd("lu_wb", 2'b00, 2'b00);
        tick();
        clr_in(); settle();
        chk_ctl("lu_done_ctl", C_IDLE);
        tick();
        chk("lu_stall_cnt", stall_cnt, exp_stall);

        // Taken branch with a simultaneous RAW hazard: branch wins
        ex_br_taken = 1'b1; ex_rd = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; settle();
        chk_ctl("br_ctl", C_BR);
        tick();
        ex_br_taken = 1'b0; settle();
        chk_ctl("redir_ctl", C_REDIR);
        tick();
        clr_in(); settle();
        chk_ctl("post_br_ctl", C_IDLE);
        tick();
        chk("br_flush_cnt", flush_cnt, exp_flush);
        chk("br_stall_cnt", stall_cnt, exp_stall);

        // Data memory busy 5 cycles, completes on the 6th
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk_ctl("mw_ctl", C_KEEP);
            tick();
        end
        dmem_ready = 1'b1; settle();
        chk_ctl("mw_ready_ctl", C_KEEP);
        tick();
        dmem_req = 1'b0; dmem_ready = 1'b0; settle();
        chk_ctl("mw_exit_ctl", C_IDLE);
        tick();
        chk("mw_stall_cnt", stall_cnt, exp_stall);

        // Memory never answers: error pulse in the 64th wait cycle
        dmem_req = 1'b1;
        for (int i = 1; i < 64; i++) begin
            settle();
            chk_ctl("to_wait_ctl", C_KEEP);
            tick();
        end
        settle();
        chk_ctl("to_err_ctl", C_TOUT);
        tick();
        dmem_req = 1'b0; settle();
        chk_ctl("to_exit_ctl", C_IDLE);
        tick();
        chk("to_stall_cnt", stall_cnt, exp_stall);

        // Asynchronous reset in the middle of a memory wait
        dmem_req = 1'b1;
        settle();
        chk_ctl("rw_enter_ctl", C_KEEP);
        tick();
        settle();
        chk_ctl("rw_wait_ctl", C_KEEP);
        #1 rst = 1'b1;
        settle();
        exp_stall = 0; exp_flush = 0;
        chk_ctl("rw_rst_ctl", C_RST);
        chk("rw_rst_stall_cnt", stall_cnt, 32'd0);
        chk("rw_rst_flush_cnt", flush_cnt, 32'd0);
        tick(); tick();
        rst = 1'b0;
        clr_in(); settle();
        chk_ctl("rw_run_ctl", C_IDLE);
        tick();

        // Load-use stall still works after reset
        ex_rd = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; settle();
        chk_ctl("rw_lu_ctl", C_STALL);
        tick();
        clr_in(); settle();
        chk("rw_lu_stall_cnt", stall_cnt, exp_stall);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
